// File: rtl/touch_pkg.sv
// touch_pkg
// Shared definitions for the XPT2046/ADS7843-style touch responder:
//   - state_t       : responder FSM states
//   - CH_*          : A2..A0 channel codes that select a sample register
//   - BIT_*         : bit positions inside the 8-bit control byte
//   - select_sample : maps a channel code onto one of the four samples
package touch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    BUSY,
    DATA
  } state_t;

  localparam logic [2:0] CH_X  = 3'b101;
  localparam logic [2:0] CH_Y  = 3'b001;
  localparam logic [2:0] CH_Z1 = 3'b011;
  localparam logic [2:0] CH_Z2 = 3'b100;

  // Control byte layout, MSB first: S A2 A1 A0 MODE SER/DFR PD1 PD0
  localparam int BIT_S    = 7;
  localparam int BIT_A2   = 6;
  localparam int BIT_A0   = 4;
  localparam int BIT_MODE = 3;
  localparam int BIT_PD0  = 0;

  // Unknown channel codes read back as zero so that the master sees a
  // harmless value instead of a stale conversion.
  function automatic logic [11:0] select_sample(
    input logic [2:0]  addr,
    input logic [11:0] x,
    input logic [11:0] y,
    input logic [11:0] z1,
    input logic [11:0] z2
  );
    logic [11:0] value;
    value = 12'h000;
    case (addr)
      CH_X:    value = x;
      CH_Y:    value = y;
      CH_Z1:   value = z1;
      CH_Z2:   value = z2;
      default: value = 12'h000;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync
// Brings the asynchronous SPI pins into the CLK_50 domain and derives SCLK
// edge strobes from the synchronized clock.
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   sclk, cs_n, mosi: raw SPI pins
//   sclk_rise       : one-cycle strobe on a synchronized SCLK 0->1
//   sclk_fall       : one-cycle strobe on a synchronized SCLK 1->0
//   cs_active       : synchronized chip select, active-high
//   mosi_s          : synchronized MOSI, aligned with the edge strobes
module spi_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_active,
  output logic mosi_s
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;

  // Two-flop synchronizers plus one extra SCLK flop for edge detection.
  // CS resets to the deasserted level so a reset always lands in IDLE
  // and any frame in flight is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_active = ~cs_sync[1];
  assign mosi_s    = mosi_sync[1];

endmodule

// File: rtl/touch_spi_responder.sv
// touch_spi_responder
// SPI slave that answers XPT2046-style control bytes with 12- or 8-bit
// results from the sample inputs and drives the active-low pen interrupt.
// Everything runs on CLK_50 by oversampling the SPI pins.
// Ports:
//   CLK_50, reset_reset_n      : clock and async active-low reset
//   spi_sclk/cs_n/mosi/miso    : SPI mode-0 slave pins
//   pen_irq_n                  : pen interrupt, active-low
//   pen_down                   : panel touched (CLK_50 synchronous)
//   x/y/z1/z2_sample           : conversion values, snapshotted per command
//   cmd_valid, cmd_byte        : completed control byte strobe and value
module touch_spi_responder
  import touch_pkg::*;
(
  input  logic        CLK_50,
  input  logic        reset_reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        pen_irq_n,
  input  logic        pen_down,
  input  logic [11:0] x_sample,
  input  logic [11:0] y_sample,
  input  logic [11:0] z1_sample,
  input  logic [11:0] z2_sample,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte
);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_active;
  logic mosi_s;

  spi_pin_sync u_sync (
    .clk       (CLK_50),
    .rst_n     (reset_reset_n),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_active (cs_active),
    .mosi_s    (mosi_s)
  );

  state_t      state, state_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [6:0]  cmd_sr, cmd_sr_n;
  logic [11:0] out_sr, out_sr_n;
  logic        mode8, mode8_n;
  logic        irq_en, irq_en_n;
  logic        miso_n;
  logic        cmd_valid_n;
  logic [7:0]  cmd_byte_n;
  logic        pen_irq_n_n;

  // The shift register keeps the first seven bits; the eighth comes
  // straight from MOSI so the full byte is available on the last rise.
  logic [7:0] cmd_full;
  logic [4:0] last_bit;
  logic       in_frame_n;

  assign cmd_full = {cmd_sr, mosi_s};
  assign last_bit = mode8 ? 5'd7 : 5'd11;

  // State and output registers.
  always_ff @(posedge CLK_50 or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      cmd_sr    <= 7'd0;
      out_sr    <= 12'd0;
      mode8     <= 1'b0;
      irq_en    <= 1'b1;
      spi_miso  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= 8'h00;
      pen_irq_n <= 1'b1;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      cmd_sr    <= cmd_sr_n;
      out_sr    <= out_sr_n;
      mode8     <= mode8_n;
      irq_en    <= irq_en_n;
      spi_miso  <= miso_n;
      cmd_valid <= cmd_valid_n;
      cmd_byte  <= cmd_byte_n;
      pen_irq_n <= pen_irq_n_n;
    end
  end

  // Next-state logic. A deasserted CS overrides every state and any SCLK
  // edge seen in the same cycle, discarding a partial command without
  // touching irq_en or cmd_byte.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    cmd_sr_n    = cmd_sr;
    out_sr_n    = out_sr;
    mode8_n     = mode8;
    irq_en_n    = irq_en;
    miso_n      = spi_miso;
    cmd_valid_n = 1'b0;
    cmd_byte_n  = cmd_byte;

    if (!cs_active) begin
      state_n   = IDLE;
      bit_cnt_n = 5'd0;
      miso_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_n  = 1'b0;
          state_n = WAIT_START;
        end

        // Leading zeros are skipped; the first 1 is the start bit.
        WAIT_START: begin
          if (sclk_fall) miso_n = 1'b0;
          if (sclk_rise && mosi_s) begin
            cmd_sr_n  = 7'h01;
            bit_cnt_n = 5'd1;
            state_n   = CMD;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            cmd_sr_n  = cmd_full[6:0];
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              cmd_byte_n  = cmd_full;
              cmd_valid_n = 1'b1;
              irq_en_n    = ~cmd_full[BIT_PD0];
              mode8_n     = cmd_full[BIT_MODE];
              out_sr_n    = select_sample(cmd_full[BIT_A2:BIT_A0], x_sample,
                                          y_sample, z1_sample, z2_sample);
              bit_cnt_n   = 5'd0;
              state_n     = BUSY;
            end
          end
        end

        BUSY: begin
          if (sclk_fall) miso_n = 1'b0;
          if (sclk_rise) begin
            bit_cnt_n = 5'd0;
            state_n   = DATA;
          end
        end

        // Result bits leave MSB first on falls; rises count what the
        // master has sampled. Shifting all 12 bits also covers 8-bit mode,
        // which simply stops after sample[11:4].
        DATA: begin
          if (sclk_fall) begin
            miso_n   = out_sr[11];
            out_sr_n = {out_sr[10:0], 1'b0};
          end
          if (sclk_rise) begin
            if (bit_cnt == last_bit) state_n = WAIT_START;
            else                     bit_cnt_n = bit_cnt + 5'd1;
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // The pen interrupt is suppressed from the start bit until the frame
  // ends, so looking at the next state masks it in the detection cycle.
  assign in_frame_n = (state_n == CMD) || (state_n == BUSY) || (state_n == DATA);

  always_comb begin
    pen_irq_n_n = 1'b1;
    if (!in_frame_n) pen_irq_n_n = ~(pen_down & irq_en_n);
  end

endmodule

// File: doc/touch_spi_responder.md
# touch_spi_responder

XPT2046/ADS7843-compatible touch-controller SPI responder: the slave end of the `spi_touch` link, answering control bytes from the Nios SPI master with 12- or 8-bit conversion results taken from sample registers, and driving the active-low pen interrupt. It is used as a drop-in stand-in for the touch chip on GPIO_0[22:27] for board bring-up and system simulation. It runs entirely in the CLK_50 domain by oversampling the SPI pins.

## Interface
- No parameters. SCLK must not exceed 2.5 MHz, so each half-period is at least 10 CLK_50 cycles.
- CLK_50  in  1  system clock, 50 MHz
- reset_reset_n  in  1  reset; asynchronous assert, active-low
- spi_sclk  in  1  SPI clock from master; idles low (mode 0)
- spi_cs_n  in  1  chip select, active-low
- spi_mosi  in  1  master data out
- spi_miso  out  1  responder data out; reset 0
- pen_irq_n  out  1  pen interrupt, active-low; reset 1
- pen_down  in  1  synchronous to CLK_50; 1 = panel touched
- x_sample, y_sample, z1_sample, z2_sample  in  12 each  conversion values, sampled at latch time
- cmd_valid  out  1  one-cycle pulse when a control byte completes; reset 0
- cmd_byte  out  8  last completed control byte; reset 8'h00

## Operation
- `spi_sclk`, `spi_cs_n` and `spi_mosi` pass through 2-flop synchronizers. Rise and fall edges of SCLK are detected on the synchronized copy.
- **Control byte format**, MSB first: S, A2, A1, A0, MODE, SER/DFR, PD1, PD0. MODE=1 selects 8-bit results. SER/DFR and PD1 are ignored. PD0=0 enables the pen IRQ.
- **IDLE**
  - Entered whenever synced CS is high; MISO=0.
  - CS falling → WAIT_START.
- **WAIT_START**
  - On each SCLK rise, sample MOSI. A 0 is ignored (leading zeros).
  - A 1 is the start bit: → CMD, with bit count = 1.
- **CMD**
  - Shift MOSI in on each SCLK rise.
  - On the 8th bit (PD0):
    - Latch `cmd_byte`; pulse `cmd_valid`.
    - Update `irq_en` = ~PD0.
    - Snapshot the result: A2..A0 = 101 → x, 001 → y, 011 → z1, 100 → z2, any other code → 12'h000.
    - → BUSY.
- **BUSY**
  - Covers the falling edge after rise 8; MISO=0 (busy slot).
  - The next SCLK rise → DATA.
- **DATA**
  - On each SCLK fall, MISO presents the next result bit MSB first: D11..D0 for 12-bit mode, or sample[11:4] for 8-bit mode.
  - After the rise that samples the last bit: MISO=0 on the following fall, → WAIT_START.
  - Start bits arriving during DATA are ignored (no overlapped conversions).
- **pen_irq_n**
  - Registered value = ~(pen_down & irq_en).
  - Forced to 1 from start-bit detection through return to WAIT_START or IDLE.
  - `irq_en` resets to 1.
- **CS high mid-frame**, in any state: → IDLE within 3 CLK_50 cycles.
  - MISO=0; the partial command is discarded.
  - No `cmd_valid` if fewer than 8 command bits were received.
  - `irq_en` and `cmd_byte` are unchanged.
- **Reset mid-frame**: all state returns to reset values immediately; the next frame starts from IDLE.

## Timing
- Pin-to-internal latency is 2 cycles (synchronizer) plus 1 cycle (edge register).
  - MISO updates 3–4 CLK_50 cycles after the SCLK fall at the pin, well within the 10-cycle half-period.
- `cmd_valid` asserts 3–4 cycles after the 8th SCLK rise and lasts exactly 1 cycle.
- **12-bit frame**: 8 command clocks + 1 busy clock + 12 data clocks. The master samples D11 on rise 10 and D0 on rise 21.
  - Typical 24-clock frame: the remaining clocks return 0.
- **8-bit frame**: data is sampled on rises 10–17.
- Simultaneous CS rise and SCLK edge in the same cycle: CS wins and the edge is ignored.
- `pen_irq_n` follows a `pen_down` change 1 cycle later when not in a frame.

## Structure
- Package `touch_pkg`:
  - State enum: IDLE, WAIT_START, CMD, BUSY, DATA.
  - Channel constants: CH_X=3'b101, CH_Y=3'b001, CH_Z1=3'b011, CH_Z2=3'b100.
  - Control-byte bit index constants.
- Sub-module `spi_pin_sync`:
  - 2-flop synchronizers for SCLK, CS and MOSI.
  - Emits `sclk_rise`, `sclk_fall`, `cs_active` and `mosi_s`.
- Top module: FSM, 5-bit bit counter, 8-bit command shift register, 12-bit output shift register.

## Test plan
- Reset, then idle: `spi_miso`=0, `pen_irq_n`=1, `cmd_byte`=00, `cmd_valid`=0.
- x_sample=12'hA5C, send 8'hD0 then 16 clocks at 2 MHz → read 16'h52E0 (busy 0, D11..D0, then 3 zeros); `cmd_valid` pulse with `cmd_byte`=D0.
- y_sample=12'h3F1, send 8'h98 (8-bit mode, Y) → data byte 8'h3F on rises 10–17.
- Send two zero bytes, then 8'h90 → leading zeros ignored, Y result returned; unused channel 8'hA0 → 12'h000.
- pen_down=1 with irq enabled: `pen_irq_n`=0; during a frame `pen_irq_n`=1; after command 8'hD1 (PD0=1), `pen_irq_n` stays 1 with pen_down=1.
- CS deasserted after 5 command bits → IDLE, no `cmd_valid`, MISO=0; the next full frame reads correctly. Repeat with reset asserted mid-DATA.
